// File: rtl/instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_pkg
// Shared definitions for the instruction encoder / program loader:
//   - cmd_kind_e : symbolic instruction classes accepted on the command port
//                  (codes 6 and 7 are illegal and have no enum member)
//   - OP_*       : MIPS primary opcodes, identical to the main decoder's
//   - state_e    : loader FSM states
//   - kind_is_legal / encode_instr : combinational helpers
// -----------------------------------------------------------------------------
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        KIND_RTYPE = 3'd0,
        KIND_LW    = 3'd1,
        KIND_SW    = 3'd2,
        KIND_BEQ   = 3'd3,
        KIND_ADDI  = 3'd4,
        KIND_J     = 3'd5
    } cmd_kind_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic kind_is_legal(input logic [2:0] kind);
        return (kind <= 3'd5);
    endfunction

    // Builds the 32-bit instruction word. Fields not used by a class are
    // ignored; illegal kinds produce zero (they are never enqueued anyway).
    function automatic logic [31:0] encode_instr(
        input logic [2:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [5:0]  funct,
        input logic [25:0] imm
    );
        logic [31:0] word;
        word = 32'd0;
        case (kind)
            KIND_RTYPE: word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
            KIND_LW:    word = {OP_LW,   rs, rt, imm[15:0]};
            KIND_SW:    word = {OP_SW,   rs, rt, imm[15:0]};
            KIND_BEQ:   word = {OP_BEQ,  rs, rt, imm[15:0]};
            KIND_ADDI:  word = {OP_ADDI, rs, rt, imm[15:0]};
            KIND_J:     word = {OP_J,    imm[25:0]};
            default:    word = 32'd0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/instr_encoder_fifo2.sv
// -----------------------------------------------------------------------------
// enc_fifo2
// Two-entry, 32-bit synchronous FIFO holding encoded words between the
// command port and the imem write port.
//   clk, reset : clock, synchronous active-high reset (empties FIFO, zeroes
//                storage so the head reads 0 after reset)
//   push, din  : enqueue din (ignored when full)
//   pop        : dequeue head (ignored when empty)
//   full/empty : occupancy flags
//   head       : oldest entry, valid when !empty
// -----------------------------------------------------------------------------
module enc_fifo2 (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] din,
    output logic        full,
    output logic        empty,
    output logic [31:0] head
);

    logic [31:0] mem_q [2];
    logic [31:0] mem_d [2];
    logic        wr_sel_q, wr_sel_d;
    logic        rd_sel_q, rd_sel_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        push_ok;
    logic        pop_ok;

    always_comb begin
        full    = (cnt_q == 2'd2);
        empty   = (cnt_q == 2'd0);
        head    = mem_q[rd_sel_q];
        push_ok = push && !full;
        pop_ok  = pop && !empty;

        wr_sel_d = push_ok ? ~wr_sel_q : wr_sel_q;
        rd_sel_d = pop_ok  ? ~rd_sel_q : rd_sel_q;

        cnt_d = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_comb begin
                mem_d[gi] = mem_q[gi];
                if (push_ok && (wr_sel_q == 1'(gi))) begin
                    mem_d[gi] = din;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    mem_q[gi] <= 32'd0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Encodes symbolic instruction commands into MIPS words and writes them
// sequentially into instruction memory starting at a programmable base.
//   start/base            : begin a load at word address base (IDLE only)
//   cmd_* (valid/ready)   : command stream; cmd_last ends the program
//   imem_stall            : memory back-pressure
//   imem_we/addr/wd       : memory write port (combinational from FIFO head)
//   busy/done             : not-idle flag / one-cycle end-of-load pulse
//   err/ovf               : sticky illegal-kind / dropped-for-full flags
//   count                 : words written since the last start
// -----------------------------------------------------------------------------
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_kind,
    input  logic [4:0]    cmd_rs,
    input  logic [4:0]    cmd_rt,
    input  logic [4:0]    cmd_rd,
    input  logic [5:0]    cmd_funct,
    input  logic [25:0]   cmd_imm,
    input  logic          cmd_last,
    input  logic          imem_stall,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wd,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          ovf,
    output logic [AW:0]   count
);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rsv_q, rsv_d;
    logic [AW:0]   count_q, count_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   fifo_head;
    logic          fifo_push;
    logic          cmd_fire;
    logic          cmd_legal;
    logic          mem_full;
    logic          write;
    logic [31:0]   enc_word;

    always_comb begin
        cmd_ready = (state_q == ST_LOAD) && !fifo_full;
        cmd_fire  = cmd_valid && cmd_ready;
        cmd_legal = kind_is_legal(cmd_kind);
        // Reserve pointer is one bit wider than an address so "all slots
        // taken" is representable without wrapping.
        mem_full  = (rsv_q == (AW+1)'(DEPTH));
        fifo_push = cmd_fire && cmd_legal && !mem_full;
        write     = !fifo_empty && !imem_stall;
        enc_word  = encode_instr(cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_funct, cmd_imm);

        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rsv_d    = rsv_q;
        count_d  = count_q;
        err_d    = err_q;
        ovf_d    = ovf_q;

        if (write) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
        end
        if (fifo_push) begin
            rsv_d = rsv_q + 1'b1;
        end
        if (cmd_fire && !cmd_legal) begin
            err_d = 1'b1;
        end
        if (cmd_fire && cmd_legal && mem_full) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    wr_ptr_d = base;
                    rsv_d    = {1'b0, base};
                    count_d  = '0;
                    err_d    = 1'b0;
                    ovf_d    = 1'b0;
                end
            end
            ST_LOAD: begin
                if (cmd_fire && cmd_last) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Leave as soon as the FIFO drains: either already empty, or
                // holding one word that is being written this cycle. No push
                // can happen in FLUSH, so this is exact.
                if (fifo_empty || (!fifo_full && write)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rsv_q    <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rsv_q    <= rsv_d;
            count_q  <= count_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
        end
    end

    enc_fifo2 u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (write),
        .din   (enc_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign imem_we   = write;
    assign imem_addr = wr_ptr_q;
    assign imem_wd   = fifo_head;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign ovf       = ovf_q;
    assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Directed bench for instr_encoder: single R-type, mixed program, stall
// back-pressure, illegal kind, memory overflow and reset mid-load. Writes
// seen on the imem port are logged and compared with hand-computed words.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_kind;
    logic [4:0]    cmd_rs, cmd_rt, cmd_rd;
    logic [5:0]    cmd_funct;
    logic [25:0]   cmd_imm;
    logic          cmd_last;
    logic          imem_stall;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wd;
    logic          busy, done, err, ovf;
    logic [AW:0]   count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0]   log_data [256];
    logic [AW-1:0] log_addr [256];
    int            wr_n = 0;

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base       (base),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_kind   (cmd_kind),
        .cmd_rs     (cmd_rs),
        .cmd_rt     (cmd_rt),
        .cmd_rd     (cmd_rd),
        .cmd_funct  (cmd_funct),
        .cmd_imm    (cmd_imm),
        .cmd_last   (cmd_last),
        .imem_stall (imem_stall),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wd    (imem_wd),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .ovf        (ovf),
        .count      (count)
    );

    always #5 clk = ~clk;

    // Write monitor: the strobe is combinational, so sample mid-cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1 && wr_n < 256) begin
            log_addr[wr_n] = imem_addr;
            log_data[wr_n] = imem_wd;
            wr_n = wr_n + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert = n_assert + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] b);
        base  = b;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Presents one command and holds it until accepted (bounded wait).
    task automatic send(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] fn, input logic [25:0] imm,
                        input logic last, output int waited);
        cmd_kind  = k;
        cmd_rs    = rs;
        cmd_rt    = rt;
        cmd_rd    = rd;
        cmd_funct = fn;
        cmd_imm   = imm;
        cmd_last  = last;
        cmd_valid = 1'b1;
        waited    = 0;
        while (cmd_ready !== 1'b1 && waited < 40) begin
            step();
            waited = waited + 1;
        end
        chk("send_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
        $display("cmd kind=%0d rs=%0d rt=%0d rd=%0d funct=0x%0h imm=0x%0h last=%0b waited=%0d",
                 k, rs, rt, rd, fn, imm, last, waited);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            step();
            n = n + 1;
        end
        chk("done_seen", 32'(done), 32'd1);
        step();
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic chk_log(input string tag, input int idx, input int addr, input logic [31:0] data);
        if (idx < wr_n) begin
            chk({tag, "_addr"}, 32'(log_addr[idx]), 32'(addr));
            chk({tag, "_data"}, log_data[idx], data);
        end else begin
            chk({tag, "_present"}, 32'(idx < wr_n), 32'd1);
        end
        $display("write check %s idx=%0d addr=%0d data=0x%08h", tag, idx, addr, data);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_imem_we"},   32'(imem_we),   32'd0);
        chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_imem_wd"},   imem_wd,        32'd0);
        chk({tag, "_flags"},     32'({busy, done, err, ovf}), 32'd0);
        chk({tag, "_count"},     32'(count),     32'd0);
    endtask

    initial begin
        int w;
        int s;

        reset      = 1'b1;
        start      = 1'b0;
        base       = '0;
        cmd_valid  = 1'b0;
        cmd_kind   = 3'd0;
        cmd_rs     = '0;
        cmd_rt     = '0;
        cmd_rd     = '0;
        cmd_funct  = '0;
        cmd_imm    = '0;
        cmd_last   = 1'b0;
        imem_stall = 1'b0;
        step();
        step();
        chk_reset_outputs("por");
        reset = 1'b0;
        step();

        // Single RTYPE: add $s0,$s1,$s2
        s = wr_n;
        do_start(6'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        send(3'd0, 5'd17, 5'd18, 5'd16, 6'h20, 26'd0, 1'b1, w);
        chk("t1_we_n1",   32'(imem_we),   32'd1);
        chk("t1_addr_n1", 32'(imem_addr), 32'd0);
        chk("t1_wd_n1",   imem_wd,        32'h02328020);
        chk("t1_done_n1", 32'(done),      32'd0);
        step();
        chk("t1_done_n2",  32'(done),  32'd1);
        chk("t1_count_n2", 32'(count), 32'd1);
        step();
        chk("t1_done_n3", 32'(done), 32'd0);
        chk("t1_busy_n3", 32'(busy), 32'd0);
        chk("t1_nwr", 32'(wr_n - s), 32'd1);
        chk_log("t1_w0", s, 0, 32'h02328020);

        // Mixed program at base 8
        s = wr_n;
        do_start(6'd8);
        send(3'd1, 5'd0, 5'd2, 5'd0, 6'd0, 26'h0044, 1'b0, w);
        send(3'd3, 5'd3, 5'd7, 5'd0, 6'd0, 26'hFFFE, 1'b0, w);
        send(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 26'h0000011, 1'b1, w);
        wait_done();
        chk("t2_count", 32'(count), 32'd3);
        chk("t2_nwr", 32'(wr_n - s), 32'd3);
        chk_log("t2_w0", s,     8,  32'h8C020044);
        chk_log("t2_w1", s + 1, 9,  32'h1067FFFE);
        chk_log("t2_w2", s + 2, 10, 32'h08000011);

        // Stall: 5 stalled cycles, FIFO fills after 2 commands
        s = wr_n;
        do_start(6'd20);
        imem_stall = 1'b1;
        send(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 26'h1, 1'b0, w);
        send(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 26'h2, 1'b0, w);
        chk("t3_ready_full", 32'(cmd_ready), 32'd0);
        chk("t3_we_stalled", 32'(imem_we),   32'd0);
        step();
        step();
        step();
        chk("t3_ready_still", 32'(cmd_ready), 32'd0);
        chk("t3_nwr_stalled", 32'(wr_n - s), 32'd0);
        imem_stall = 1'b0;
        send(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 26'h3, 1'b0, w);
        send(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 26'h4, 1'b1, w);
        wait_done();
        chk("t3_count", 32'(count), 32'd4);
        chk("t3_nwr", 32'(wr_n - s), 32'd4);
        chk_log("t3_w0", s,     20, 32'h20220001);
        chk_log("t3_w1", s + 1, 21, 32'h20220002);
        chk_log("t3_w2", s + 2, 22, 32'h20220003);
        chk_log("t3_w3", s + 3, 23, 32'h20220004);

        // Illegal kind in the middle
        s = wr_n;
        do_start(6'd30);
        send(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 26'h10, 1'b0, w);
        chk("t4_wait0", 32'(w), 32'd0);
        send(3'd6, 5'd1, 5'd2, 5'd0, 6'd0, 26'h99, 1'b0, w);
        chk("t4_wait_illegal", 32'(w), 32'd0);
        chk("t4_err_set", 32'(err), 32'd1);
        send(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 26'h11, 1'b1, w);
        chk("t4_wait2", 32'(w), 32'd0);
        wait_done();
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_ovf", 32'(ovf), 32'd0);
        chk("t4_count", 32'(count), 32'd2);
        chk("t4_nwr", 32'(wr_n - s), 32'd2);
        chk_log("t4_w0", s,     30, 32'h20220010);
        chk_log("t4_w1", s + 1, 31, 32'h20220011);

        // Overflow at the top of memory
        s = wr_n;
        do_start(6'd62);
        chk("t5_err_cleared", 32'(err), 32'd0);
        send(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 26'h21, 1'b0, w);
        send(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 26'h22, 1'b0, w);
        send(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 26'h23, 1'b0, w);
        chk("t5_ovf_early", 32'(ovf), 32'd1);
        send(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 26'h24, 1'b1, w);
        wait_done();
        chk("t5_ovf", 32'(ovf), 32'd1);
        chk("t5_count", 32'(count), 32'd2);
        chk("t5_nwr", 32'(wr_n - s), 32'd2);
        chk_log("t5_w0", s,     62, 32'h20220021);
        chk_log("t5_w1", s + 1, 63, 32'h20220022);

        // Reset while two words sit in the FIFO
        s = wr_n;
        do_start(6'd5);
        chk("t6_ovf_cleared", 32'(ovf), 32'd0);
        imem_stall = 1'b1;
        send(3'd7, 5'd0, 5'd0, 5'd0, 6'd0, 26'h0, 1'b0, w);
        send(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 26'h31, 1'b0, w);
        send(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 26'h32, 1'b0, w);
        chk("t6_err_before", 32'(err), 32'd1);
        chk("t6_full_before", 32'(cmd_ready), 32'd0);
        reset = 1'b1;
        step();
        imem_stall = 1'b0;
        chk_reset_outputs("t6_rst");
        step();
        chk("t6_we_rst2", 32'(imem_we), 32'd0);
        reset = 1'b0;
        step();
        chk("t6_we_after", 32'(imem_we), 32'd0);
        step();
        chk("t6_nwr_none", 32'(wr_n - s), 32'd0);
        do_start(6'd40);
        send(3'd0, 5'd17, 5'd18, 5'd16, 6'h20, 26'd0, 1'b1, w);
        wait_done();
        chk("t6_count", 32'(count), 32'd1);
        chk("t6_nwr", 32'(wr_n - s), 32'd1);
        chk_log("t6_w0", s, 40, 32'h02328020);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and program loader for the single-cycle MIPS core. It is the inverse of the main decoder: it accepts symbolic instruction commands (class, register fields, immediate) over a valid/ready handshake. It encodes each into a 32-bit MIPS word, buffers it in a 2-entry FIFO, and writes it sequentially into the instruction memory's write port from a programmable base address. Used by the boot/test harness to place programs in imem before the core is released from reset.

## Interface
- DEPTH, 64: imem size in words; AW = $clog2(DEPTH) is a localparam.
- clk  in  1  clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; honoured only in IDLE.
- base  in  AW  first word address; sampled on an accepted start.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  encoder can take a command.
- cmd_kind  in  3  0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J, 6–7 illegal.
- cmd_rs, cmd_rt, cmd_rd  in  5 each  register fields.
- cmd_funct  in  6  R-type funct.
- cmd_imm  in  26  immediate; [15:0] for I-type, [25:0] for J.
- cmd_last  in  1  marks the final command of the program.
- imem_stall  in  1  imem cannot take a write this cycle.
- imem_we  out  1  write strobe.
- imem_addr  out  AW  word address.
- imem_wd  out  32  instruction word.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at the end of a load.
- err  out  1  sticky: an illegal cmd_kind was seen.
- ovf  out  1  sticky: a command was dropped because memory was full.
- count  out  AW+1  words written since the last start.

## Operation
- **States.**
  - IDLE → LOAD on start. This loads the write pointer and reserve pointer with base, and clears count, err and ovf.
  - LOAD → FLUSH when a command with cmd_last is accepted.
  - FLUSH → DONE when the FIFO is empty.
  - DONE → IDLE unconditionally; done is high only in DONE.
- **cmd_ready.** Equals (state==LOAD) && !fifo_full. Full is evaluated before the pop, so there is no push into a full FIFO even with a simultaneous pop.
- **Encoding**, applied on acceptance:
  - RTYPE = {000000, rs, rt, rd, 00000, funct}
  - LW = {100011, rs, rt, imm[15:0]}
  - SW = {101011, rs, rt, imm[15:0]}
  - BEQ = {000100, rs, rt, imm[15:0]}
  - ADDI = {001000, rs, rt, imm[15:0]}
  - J = {000010, imm[25:0]}
  - Unused fields are ignored.
- **Illegal kind.** The handshake completes and nothing is enqueued. err is set. cmd_last on an illegal command still moves to FLUSH.
- **Address reservation.** Each legal accepted command takes a slot; the reserve pointer increments.
  - When the reserve pointer equals DEPTH (width AW+1, no wrap), further legal commands are accepted and dropped, and ovf is set.
  - Addresses never wrap past DEPTH-1.
- **Write port.** imem_we = fifo_nonempty && !imem_stall and is combinational from the FIFO head. imem_addr = write pointer, imem_wd = head word. On each write, pop the FIFO, increment the write pointer, and increment count.
- **start outside IDLE** is ignored.
- **Reset** (including mid-load) gives the following; no write occurs in the cycle after reset:
  - state IDLE, FIFO empty;
  - cmd_ready=0, imem_we=0, imem_addr=0, imem_wd=0;
  - busy=0, done=0, err=0, ovf=0, count=0.

## Timing
- Command accepted at edge N → word at the FIFO head in cycle N+1 → imem_we is high in cycle N+1 if imem_stall=0, and the write commits at edge N+2.
- Sustained throughput is 1 word/cycle with imem_stall low.
- With imem_stall held high, cmd_ready falls after 2 accepted commands.
- Accepting the last command at edge N with no stalls:
  - FLUSH in N+1 with 1 word pending;
  - DONE in N+2;
  - done=1 for exactly cycle N+2;
  - IDLE at N+3.
- When the last command is illegal and the FIFO is empty, FLUSH lasts 1 cycle.

## Structure
- Shared package: cmd_kind enum, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), and the state enum. These opcode constants are the same ones the main decoder uses.
- Sub-module `enc_fifo2`: a 2-entry, 32-bit synchronous FIFO with push, pop, full, empty and head.
- Encoding is a combinational function in the package.

## Test plan
- **Single RTYPE.** base=0, start, then RTYPE rs=17 rt=18 rd=16 funct=0x20 with last → one write of 0x02328020 at addr 0, count=1, done pulses 2 cycles after acceptance.
- **Mixed program.** base=8, LW rs=0 rt=2 imm=0x0044, then BEQ rs=3 rt=7 imm=0xFFFE, then J imm=0x0000011 (last) → writes 0x8C020044@8, 0x1067FFFE@9, 0x08000011@10, count=3.
- **Stall.** Hold imem_stall for 5 cycles while streaming 4 commands → cmd_ready low after 2; all 4 written in order at consecutive addresses once the stall drops.
- **Illegal kind.** Stream ADDI, kind=6, ADDI → err=1, only 2 writes at consecutive addresses, handshake never blocks.
- **Overflow.** DEPTH=64, base=62, 4 legal commands → writes at 62 and 63 only, ovf=1, count=2, done still pulses.
- **Reset mid-load.** Reset while 2 words are in the FIFO → no imem_we afterward, all outputs zero; a new start loads correctly.
